// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit core: opcodes, field positions,
// the issued-instruction record and immediate helper.
package cpu_isa_pkg;

    localparam int DATA_W   = 16;
    localparam int REG_W    = 3;
    localparam int IMM_W    = 7;
    localparam int ALU_OP_W = 4;

    typedef enum logic [2:0] {
        OP_ALU  = 3'b000,
        OP_ADDI = 3'b001,
        OP_RSVD = 3'b010,
        OP_LUI  = 3'b011,
        OP_SW   = 3'b100,
        OP_LW   = 3'b101,
        OP_BR   = 3'b110,
        OP_JALR = 3'b111
    } op_e;

    // Non-register-register ops and bubbles drive this alu_op code.
    localparam logic [ALU_OP_W-1:0] ALU_OP_NONE = 4'b0000;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int RA_MSB   = 12;
    localparam int RA_LSB   = 10;
    localparam int RB_MSB   = 9;
    localparam int RB_LSB   = 7;
    localparam int AOP_MSB  = 6;
    localparam int AOP_LSB  = 3;
    localparam int RC_MSB   = 2;
    localparam int RC_LSB   = 0;
    localparam int IMM_MSB  = 6;
    localparam int LUI_MSB  = 9;

    typedef struct packed {
        logic                valid;
        logic [2:0]          op;
        logic [ALU_OP_W-1:0] alu_op;
        logic [DATA_W-1:0]   s1;
        logic [DATA_W-1:0]   s2;
        logic [DATA_W-1:0]   aux;
        logic [REG_W-1:0]    dest;
        logic [DATA_W-1:0]   pc;
    } issue_t;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Fetch-side handshake and issue bus of the ALU issue stage.
interface alu_issue_stage_if;
    import cpu_isa_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   in_instr;
    logic [DATA_W-1:0]   in_pc;
    logic                out_valid;
    logic [2:0]          out_op;
    logic [ALU_OP_W-1:0] out_alu_op;
    logic [DATA_W-1:0]   out_s1;
    logic [DATA_W-1:0]   out_s2;
    logic [DATA_W-1:0]   out_aux;
    logic [REG_W-1:0]    out_dest;
    logic [DATA_W-1:0]   out_pc;

    modport master (
        output in_valid, in_instr, in_pc,
        input  in_ready, out_valid, out_op, out_alu_op, out_s1, out_s2,
               out_aux, out_dest, out_pc
    );

    modport slave (
        input  in_valid, in_instr, in_pc,
        output in_ready, out_valid, out_op, out_alu_op, out_s1, out_s2,
               out_aux, out_dest, out_pc
    );
endinterface

// File: rtl/operand_fwd_mux.sv
// Resolves one source operand: r0 -> 0, then EX result, then WB result,
// then register-file data.
module operand_fwd_mux
    import cpu_isa_pkg::*;
(
    input  logic [REG_W-1:0]  addr,
    input  logic [DATA_W-1:0] rf_data,
    input  logic              ex_valid,
    input  logic [REG_W-1:0]  ex_dest,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] data
);
    always_comb begin
        data = rf_data;
        if (addr == '0)
            data = '0;
        else if (ex_valid && ex_dest == addr)
            data = ex_data;
        else if (wb_valid && wb_dest == addr)
            data = wb_data;
    end
endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue register ahead of the ALU: operand select with forwarding,
// load-use bubble insertion, stall and flush.
module alu_issue_stage
    import cpu_isa_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    alu_issue_stage_if.slave   io,
    output logic [REG_W-1:0]   rf_addr_a,
    output logic [REG_W-1:0]   rf_addr_b,
    output logic [REG_W-1:0]   rf_addr_c,
    input  logic [DATA_W-1:0]  rf_data_a,
    input  logic [DATA_W-1:0]  rf_data_b,
    input  logic [DATA_W-1:0]  rf_data_c,
    input  logic               ex_fwd_valid,
    input  logic [REG_W-1:0]   ex_fwd_dest,
    input  logic [DATA_W-1:0]  ex_fwd_data,
    input  logic               wb_fwd_valid,
    input  logic [REG_W-1:0]   wb_fwd_dest,
    input  logic [DATA_W-1:0]  wb_fwd_data,
    input  logic               stall,
    input  logic               flush
);
    localparam int NUM_SRC = 3;

    logic [DATA_W-1:0]                instr;
    logic [2:0]                       op;
    logic [NUM_SRC-1:0][REG_W-1:0]    src_addr;
    logic [NUM_SRC-1:0][DATA_W-1:0]   src_rf;
    logic [NUM_SRC-1:0][DATA_W-1:0]   src_val;
    logic [NUM_SRC-1:0]               src_used;
    logic                             hazard;
    issue_t                           nxt;
    issue_t                           q;

    assign instr     = io.in_instr;
    assign op        = instr[OP_MSB:OP_LSB];
    assign src_addr  = {instr[RC_MSB:RC_LSB], instr[RB_MSB:RB_LSB], instr[RA_MSB:RA_LSB]};
    assign src_rf    = {rf_data_c, rf_data_b, rf_data_a};
    assign rf_addr_a = src_addr[0];
    assign rf_addr_b = src_addr[1];
    assign rf_addr_c = src_addr[2];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        operand_fwd_mux u_mux (
            .addr     (src_addr[i]),
            .rf_data  (src_rf[i]),
            .ex_valid (ex_fwd_valid),
            .ex_dest  (ex_fwd_dest),
            .ex_data  (ex_fwd_data),
            .wb_valid (wb_fwd_valid),
            .wb_dest  (wb_fwd_dest),
            .wb_data  (wb_fwd_data),
            .data     (src_val[i])
        );
    end

    // src_used bit order: [2]=rC, [1]=rB, [0]=rA.
    always_comb begin
        nxt       = '0;
        src_used  = '0;
        nxt.valid = 1'b1;
        nxt.op    = op;
        nxt.dest  = instr[RA_MSB:RA_LSB];
        nxt.pc    = io.in_pc;
        case (op)
            OP_ALU: begin
                src_used   = 3'b110;
                nxt.alu_op = instr[AOP_MSB:AOP_LSB];
                nxt.s1     = src_val[1];
                nxt.s2     = src_val[2];
            end
            OP_ADDI, OP_LW: begin
                src_used = 3'b010;
                nxt.s1   = src_val[1];
                nxt.s2   = sext_imm(instr[IMM_MSB:0]);
            end
            OP_LUI: nxt.s1 = {instr[LUI_MSB:0], 6'b0};
            OP_SW: begin
                src_used = 3'b011;
                nxt.s1   = src_val[1];
                nxt.s2   = sext_imm(instr[IMM_MSB:0]);
                nxt.aux  = src_val[0];
            end
            OP_JALR: begin
                src_used = 3'b010;
                nxt.s1   = io.in_pc + 16'd1;
                nxt.aux  = src_val[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        hazard = 1'b0;
        if (io.in_valid && q.valid && q.op == OP_LW && q.dest != '0)
            for (int i = 0; i < NUM_SRC; i++)
                if (src_used[i] && src_addr[i] == q.dest)
                    hazard = 1'b1;
    end

    assign io.in_ready = !stall && !hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (flush)
            q <= '0;
        else if (stall)
            q <= q;
        else if (hazard || !io.in_valid)
            q <= '0;
        else
            q <= nxt;
    end

    assign io.out_valid  = q.valid;
    assign io.out_op     = q.op;
    assign io.out_alu_op = q.alu_op;
    assign io.out_s1     = q.s1;
    assign io.out_s2     = q.s2;
    assign io.out_aux    = q.aux;
    assign io.out_dest   = q.dest;
    assign io.out_pc     = q.pc;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue pipeline register directly upstream of the 16-bit ALU.
- Accepts one fetched instruction plus its PC and drives register-file read addresses. It forwards in-flight results and detects load-use hazards.
- Registers the ALU's op, alu_op, s_1 and s_2 operands together with a destination tag and auxiliary operand for later stages.
- Owns stall, flush and bubble insertion for the execute stage.

Parameters:
DATA_W, 16, datapath width (must equal ALU width)
REG_W, 3, register index width (8 registers, r0 reads as zero)
IMM_W, 7, signed immediate field width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  instruction present at input
in_ready  out  1  stage accepts instruction this cycle (combinational)
in_instr  in  16  instruction word
in_pc  in  16  PC of in_instr
rf_addr_a/b/c  out  3 each  read addresses = in_instr[12:10], [9:7], [2:0] (combinational)
rf_data_a/b/c  in  16 each  register-file read data, same cycle
ex_fwd_valid, ex_fwd_dest, ex_fwd_data  in  1/3/16  result of instruction currently in ALU
wb_fwd_valid, wb_fwd_dest, wb_fwd_data  in  1/3/16  result being written back
stall  in  1  downstream cannot advance
flush  in  1  squash held and incoming instruction (taken branch/jalr)
out_valid  out  1  issued instruction is real
out_op  out  3  to ALU op
out_alu_op  out  4  to ALU alu_op
out_s1, out_s2  out  16 each  to ALU s_1, s_2
out_aux  out  16  sw store data / jalr target
out_dest  out  3  destination register (in_instr[12:10])
out_pc  out  16  PC of issued instruction

Behaviour:
- Fields: op=[15:13], rA=[12:10], rB=[9:7], alu_op=[6:3], rC=[2:0], imm7=[6:0] sign-extended to 16.
- Operand mapping per op:
  - 000: s1=rB, s2=rC.
  - 001 addi: s1=rB, s2=imm.
  - 011 lui: s1={instr[9:0],6'b0}, s2=0.
  - 100 sw: s1=rB, s2=imm, aux=rA.
  - 101 lw: s1=rB, s2=imm.
  - 110 branch: s1=s2=0.
  - 111 jalr: s1=in_pc+1, s2=0, aux=rB.
  - 010 reserved: s1=s2=aux=0, issued with out_valid=1.
  - Unused aux = 0.
  - alu_op is passed through only for op 000; all other ops drive alu_op 0.
- Operand value resolution for each source register used:
  - Register 0 resolves to 0, and forwarding is ignored.
  - Otherwise, if ex_fwd_valid and the dest matches, use ex_fwd_data. EX priority is over WB.
  - Otherwise, if wb_fwd_valid and the dest matches, use wb_fwd_data.
  - Otherwise, use rf_data.
- Load-use hazard condition (hazard):
  - out_valid=1, out_op=101, out_dest!=0, and out_dest equals a source register used by the incoming instruction.
  - While hazard holds, in_ready=0.
- in_ready = !stall && !hazard. A flush does not lower in_ready.
- Per-cycle update (priority order):
  - rst: all out_* = 0, out_valid=0.
  - flush: out_valid<=0 and all out_* <= 0. Incoming instruction is discarded even if in_valid=1, and even if stall=1.
  - stall: all outputs hold.
  - hazard: insert bubble (out_valid<=0, out_* <= 0). Upstream holds the instruction; it issues on the next cycle, when the lw has moved on and forwards via ex_fwd.
  - in_valid: register the decoded instruction with out_valid<=1.
  - else: bubble.
- Latency: 1 cycle, input to registered output.
- Bubbles drive op=000, alu_op=0000, s1=s2=0. Gating flag writes on out_valid=0 is the responsibility of the downstream stage.
- Arithmetic: pc+1 and sign-extension are modulo 2^16. pc=16'hFFFF gives s1=0.
- Reset asserted mid-operation clears state immediately. First accept is on the first clock edge after rst deasserts.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - op codes OP_ALU, OP_ADDI, OP_LUI, OP_SW, OP_LW, OP_BR, OP_JALR, OP_RSVD;
  - the alu_op codes;
  - field bit positions;
  - DATA_W and REG_W.
- One sub-module, operand_fwd_mux: a combinational register-0/EX/WB/RF select. It is instantiated three times, once for each of a, b and c.

Test Plan:
1. Reset, then instr 0x1A2B (op000, rA=6, rB=4, alu_op=5, rC=3), rf b=0x0010, c=0x0003 -> next cycle out_valid=1, op=000, alu_op=0101, s1=0x0010, s2=0x0003, dest=6.
2. addi with rB=2, imm7=0x7F; ex_fwd dest=2 data=0x1234; wb_fwd dest=2 data=0xAAAA -> s1=0x1234 (EX wins), s2=0xFFFF.
3. lw into r5 issued, then op000 reading rC=5 -> cycle 2: in_ready=0, out_valid=0. Cycle 3 with ex_fwd dest=5 data=0x00C0 -> issues with s2=0x00C0.
4. stall=1 for 3 cycles with in_valid=1 -> outputs unchanged and in_ready=0 throughout. Deasserting stall issues the held instruction once.
5. flush=1 with stall=1 and in_valid=1 -> next cycle out_valid=0, outputs zero. Instruction not issued.
6. jalr at in_pc=0xFFFF, rB=0 -> s1=0x0000, aux=0x0000. sw reading r0 with wb_fwd dest=0 -> aux=0.
